// File: rtl/ula_cmp_serial.sv
// Digit-serial comparator for the ULA: MSB-first, DIGIT bits per cycle, six relations, signed/unsigned.
// Optional ULA_CMP_EARLY_EXIT_EN: finish on the first differing digit instead of always N cycles.
module ula_cmp_serial #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int DIGIT     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IN_WIDTH-1:0]  a_i,
    input  logic [IN_WIDTH-1:0]  b_i,
    input  logic [2:0]           op_i,
    input  logic                 is_signed_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OUT_WIDTH-1:0] out_o,
    output logic                 eq_o,
    output logic                 lt_o,
    output logic                 op_err_o
);

    localparam int N  = IN_WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((IN_WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("ula_cmp_serial: DIGIT must divide IN_WIDTH");
        end
    endgenerate

    logic [1:0]          state_q;
    logic [IN_WIDTH-1:0] a_q, b_q;
    logic [2:0]          op_q;
    logic [CW-1:0]       cnt_q;
    logic                dec_q, lt_acc_q;
    logic                res_q, eq_q, lt_q, err_q;

    logic [DIGIT-1:0]    da, db;
    logic                diff, dec_d, lt_acc_d, fin, res_d;
    logic [IN_WIDTH-1:0] sgn_mask;

    // Flipping both MSBs maps two's-complement order onto unsigned order.
    assign sgn_mask = {is_signed_i, {(IN_WIDTH-1){1'b0}}};

    // Operands shift left each RUN cycle, so the current digit is always on top.
    always_comb begin
        da       = a_q[IN_WIDTH-1 -: DIGIT];
        db       = b_q[IN_WIDTH-1 -: DIGIT];
        diff     = (da != db);
        dec_d    = dec_q | diff;
        lt_acc_d = dec_q ? lt_acc_q : (da < db);
`ifdef ULA_CMP_EARLY_EXIT_EN
        fin      = (cnt_q == CW'(N-1)) || diff;
`else
        fin      = (cnt_q == CW'(N-1));
`endif
        res_d    = 1'b0;
        case (op_q)
            3'd0: res_d = ~dec_d;
            3'd1: res_d = dec_d;
            3'd2: res_d = lt_acc_d;
            3'd3: res_d = lt_acc_d | ~dec_d;
            3'd4: res_d = ~lt_acc_d & dec_d;
            3'd5: res_d = ~lt_acc_d;
            default: res_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            lt_acc_q <= 1'b0;
            res_q    <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid_i) begin
                    a_q      <= a_i ^ sgn_mask;
                    b_q      <= b_i ^ sgn_mask;
                    op_q     <= op_i;
                    cnt_q    <= '0;
                    dec_q    <= 1'b0;
                    lt_acc_q <= 1'b0;
                    state_q  <= S_RUN;
                end
                S_RUN: begin
                    a_q      <= a_q << DIGIT;
                    b_q      <= b_q << DIGIT;
                    cnt_q    <= cnt_q + CW'(1);
                    dec_q    <= dec_d;
                    lt_acc_q <= lt_acc_d;
                    if (fin) begin
                        state_q <= S_DONE;
                        res_q   <= res_d;
                        eq_q    <= ~dec_d;
                        lt_q    <= lt_acc_d;
                        err_q   <= (op_q > 3'd5);
                    end
                end
                S_DONE: if (out_ready_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign out_o       = {{(OUT_WIDTH-1){1'b0}}, res_q};
    assign eq_o        = eq_q;
    assign lt_o        = lt_q;
    assign op_err_o    = err_q;

endmodule
